// File: rtl/booth_mult_ctrl_pkg.sv
// Shared definitions for the radix-4 Booth multiplier sequencer and its datapath:
// state encodings, multiplier window constants and the window recode function.
package booth_mult_ctrl_pkg;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_e;

   // Multiplier window {q[i+1], q[i], q[i-1]} grouped by the Booth digit it encodes
   localparam logic [2:0] WIN_ZERO_A = 3'b000;
   localparam logic [2:0] WIN_P1_A   = 3'b001;
   localparam logic [2:0] WIN_P1_B   = 3'b010;
   localparam logic [2:0] WIN_P2     = 3'b011;
   localparam logic [2:0] WIN_M2     = 3'b100;
   localparam logic [2:0] WIN_M1_A   = 3'b101;
   localparam logic [2:0] WIN_M1_B   = 3'b110;
   localparam logic [2:0] WIN_ZERO_B = 3'b111;

   typedef struct packed {
      logic add;
      logic sub;
      logic dbl;
      logic nop;
   } recode_t;

   function automatic recode_t recode(input logic [2:0] win);
      recode_t r;
      r = '0;
      case (win)
         WIN_P1_A, WIN_P1_B: r.add = 1'b1;
         WIN_P2: begin
            r.add = 1'b1;
            r.dbl = 1'b1;
         end
         WIN_M2: begin
            r.sub = 1'b1;
            r.dbl = 1'b1;
         end
         WIN_M1_A, WIN_M1_B: r.sub = 1'b1;
         default: r.nop = 1'b1;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/booth_mult_ctrl_recoder.sv
// Combinational radix-4 Booth window recoder with enable; all controls are 0 when disabled.
// Kept standalone so the divider's SRT path can reuse it.
module booth_mult_ctrl_recoder
   import booth_mult_ctrl_pkg::*;
(
   input  logic       en_i,
   input  logic [2:0] win_i,
   output logic       add_o,
   output logic       sub_o,
   output logic       dbl_o,
   output logic       nop_o
);

   recode_t rc;

   always_comb begin
      rc = '0;
      if (en_i) rc = recode(win_i);
   end

   assign add_o = rc.add;
   assign sub_o = rc.sub;
   assign dbl_o = rc.dbl;
   assign nop_o = rc.nop;

endmodule

// File: rtl/booth_mult_ctrl.sv
// Sequencer for the radix-4 Booth multiplier: start/busy/ready handshake, iteration
// count for signed or unsigned operands, flush abort, and per-iteration recode controls.
module booth_mult_ctrl
   import booth_mult_ctrl_pkg::*;
#(
   parameter  int WIDTH = 32,
   localparam int CW    = $clog2(WIDTH/2 + 2)
)
(
   input  logic          clock,
   input  logic          reset,
   input  logic          start,
   input  logic          is_signed,
   input  logic          flush,
   input  logic [2:0]    booth_bits,
   output logic          load,
   output logic          add,
   output logic          sub,
   output logic          dbl,
   output logic          nop,
   output logic          shift,
   output logic          busy,
   output logic          ready,
   output logic [CW-1:0] iter
);

   if ((WIDTH % 2) != 0 || WIDTH < 4) begin : g_width_chk
      $error("booth_mult_ctrl: WIDTH must be even and >= 4");
   end

   // Unsigned needs one extra window to cover the zero-extended MSBs
   localparam logic [CW-1:0] LAST_S = CW'(WIDTH/2 - 1);
   localparam logic [CW-1:0] LAST_U = CW'(WIDTH/2);

   state_e        state_q, state_d;
   logic [CW-1:0] iter_q, iter_d;
   logic          mode_q, mode_d;
   logic          busy_q, ready_q;
   logic          accept, last_iter;

   assign accept    = start & ~flush & ((state_q == S_IDLE) | (state_q == S_DONE));
   assign last_iter = (iter_q == (mode_q ? LAST_S : LAST_U));

   always_comb begin
      state_d = state_q;
      iter_d  = iter_q;
      mode_d  = mode_q;
      if (flush) begin
         state_d = S_IDLE;
         iter_d  = '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  state_d = S_RUN;
                  iter_d  = '0;
                  mode_d  = is_signed;
               end
            end
            S_RUN: begin
               if (last_iter) state_d = S_DONE;
               else           iter_d  = iter_q + CW'(1);
            end
            S_DONE: begin
               iter_d = '0;
               if (start) begin
                  state_d = S_RUN;
                  mode_d  = is_signed;
               end else begin
                  state_d = S_IDLE;
               end
            end
            default: begin
               state_d = S_IDLE;
               iter_d  = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         iter_q  <= '0;
         mode_q  <= 1'b1;
         busy_q  <= 1'b0;
         ready_q <= 1'b0;
      end else begin
         state_q <= state_d;
         iter_q  <= iter_d;
         mode_q  <= mode_d;
         busy_q  <= (state_d == S_RUN);
         ready_q <= (state_d == S_DONE);
      end
   end

   booth_mult_ctrl_recoder u_recoder (
      .en_i  (busy_q),
      .win_i (booth_bits),
      .add_o (add),
      .sub_o (sub),
      .dbl_o (dbl),
      .nop_o (nop)
   );

   assign load  = accept;
   assign busy  = busy_q;
   assign shift = busy_q;
   assign ready = ready_q;
   assign iter  = iter_q;

endmodule

// File: tb/tb_booth_mult_ctrl.sv
// Directed bench for booth_mult_ctrl: a queue of expected ready cycles is filled when a
// multiply is started and drained by a monitor whenever ready is seen.
module tb_booth_mult_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0, is_signed = 1'b1, flush = 1'b0;
   logic [2:0] bits = 3'b000;
   logic       load, add, sub, dbl, nop, shift, busy, ready;
   logic [4:0] iter;

   logic       start8 = 1'b0, sgn8 = 1'b1, flush8 = 1'b0;
   logic [2:0] bits8 = 3'b000;
   logic       load8, add8, sub8, dbl8, nop8, shift8, busy8, ready8;
   logic [2:0] iter8;

   int vectors = 0;
   int miscompares = 0;
   int cyc = 0;
   int exp_q[$];

   booth_mult_ctrl #(.WIDTH(32)) dut (
      .clock(clk), .reset(rst), .start(start), .is_signed(is_signed), .flush(flush),
      .booth_bits(bits), .load(load), .add(add), .sub(sub), .dbl(dbl), .nop(nop),
      .shift(shift), .busy(busy), .ready(ready), .iter(iter)
   );

   booth_mult_ctrl #(.WIDTH(8)) dut8 (
      .clock(clk), .reset(rst), .start(start8), .is_signed(sgn8), .flush(flush8),
      .booth_bits(bits8), .load(load8), .add(add8), .sub(sub8), .dbl(dbl8), .nop(nop8),
      .shift(shift8), .busy(busy8), .ready(ready8), .iter(iter8)
   );

   initial forever #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Recode table written out independently of the design
   function automatic logic [3:0] exp_rc(input int w);
      case (w)
         0, 7:    return 4'b0001;
         1, 2:    return 4'b1000;
         3:       return 4'b1010;
         4:       return 4'b0110;
         default: return 4'b0100;
      endcase
   endfunction

   always @(negedge clk) begin : mon
      int e;
      if (!rst && ready) begin
         if (exp_q.size() == 0) begin
            check("ready_unexpected", ready, 0);
         end else begin
            e = exp_q.pop_front();
            check("ready_cycle", cyc, e);
         end
      end
   end

   task automatic wait_idle(input string tag);
      int n = 0;
      while ((busy || ready) && n < 40) begin
         @(negedge clk);
         n++;
      end
      check(tag, {31'b0, busy | ready}, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset state
      @(negedge clk); @(negedge clk);
      #1;
      check("rst_busy", busy, 0);
      check("rst_ready", ready, 0);
      check("rst_iter", iter, 0);
      check("rst_ctl", {load, add, sub, dbl, nop, shift}, 0);
      @(negedge clk);
      rst = 1'b0;

      // 1: signed 32, window 001 held
      @(negedge clk);
      bits = 3'b001; is_signed = 1'b1; start = 1'b1;
      #1 check("t1_load", load, 1);
      exp_q.push_back(cyc + 1 + 16);
      @(negedge clk);
      start = 1'b0;
      for (int k = 0; k < 16; k++) begin
         #1;
         check("t1_iter", iter, k);
         check("t1_run", {busy, shift, add, sub, dbl, nop, ready}, 7'b1110000);
         @(negedge clk);
      end
      #1;
      check("t1_done", {ready, busy, add}, 3'b100);
      @(negedge clk);
      #1 check("t1_idle", {ready, busy}, 2'b00);

      // 2: unsigned 32 -> 17 iterations
      @(negedge clk);
      is_signed = 1'b0; start = 1'b1;
      exp_q.push_back(cyc + 1 + 17);
      @(negedge clk);
      start = 1'b0;
      for (int k = 0; k < 17; k++) begin
         #1;
         check("t2_iter", iter, k);
         check("t2_busy", {busy, ready}, 2'b10);
         @(negedge clk);
      end
      #1 check("t2_done", {ready, busy}, 2'b10);
      @(negedge clk);

      // 2b: WIDTH=8 signed -> 4 iterations, window 011 gives add+dbl
      bits8 = 3'b011; sgn8 = 1'b1; start8 = 1'b1;
      #1 check("t2b_load", load8, 1);
      @(negedge clk);
      start8 = 1'b0;
      for (int k = 0; k < 4; k++) begin
         #1;
         check("t2b_iter", iter8, k);
         check("t2b_run", {busy8, ready8, add8, dbl8, sub8, nop8}, 6'b101100);
         @(negedge clk);
      end
      #1 check("t2b_done", {ready8, busy8}, 2'b10);
      @(negedge clk);
      #1 check("t2b_idle", {ready8, busy8}, 2'b00);

      // 3: sweep all windows during RUN
      @(negedge clk);
      is_signed = 1'b1; start = 1'b1;
      exp_q.push_back(cyc + 1 + 16);
      @(negedge clk);
      start = 1'b0;
      for (int w = 0; w < 8; w++) begin
         bits = w[2:0];
         #1;
         check("t3_recode", {add, sub, dbl, nop}, exp_rc(w));
         check("t3_onehot", {31'b0, $onehot({add, sub, nop})}, 1);
         check("t3_dbl", {31'b0, dbl & ~(add | sub)}, 0);
         @(negedge clk);
      end
      wait_idle("t3_finish");

      // 4: flush with start at iter 5
      @(negedge clk);
      bits = 3'b010; start = 1'b1;
      exp_q.push_back(cyc + 1 + 16);
      @(negedge clk);
      start = 1'b0;
      repeat (5) @(negedge clk);
      #1 check("t4_iter5", iter, 5);
      flush = 1'b1; start = 1'b1;
      #1 check("t4_noload", load, 0);
      void'(exp_q.pop_back());
      @(negedge clk);
      flush = 1'b0; start = 1'b0;
      #1 check("t4_flushed", {busy, ready, 5'(iter)}, 0);
      repeat (20) @(negedge clk);
      start = 1'b1;
      exp_q.push_back(cyc + 1 + 16);
      @(negedge clk);
      start = 1'b0;
      wait_idle("t4_restart");

      // 5: start held through ready -> back-to-back
      @(negedge clk);
      is_signed = 1'b1; start = 1'b1;
      exp_q.push_back(cyc + 1 + 16);
      @(negedge clk);
      #1 check("t5_run_noload", load, 0);
      repeat (16) @(negedge clk);
      #1 check("t5_done_load", {ready, load}, 2'b11);
      exp_q.push_back(cyc + 1 + 16);
      @(negedge clk);
      start = 1'b0;
      #1 check("t5_rerun", {busy, 5'(iter)}, 6'b100000);
      wait_idle("t5_finish");

      // 6: async reset mid-RUN, then start in RUN ignored
      @(negedge clk);
      bits = 3'b001; start = 1'b1;
      exp_q.push_back(cyc + 1 + 16);
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      #1 check("t6_pre", busy, 1);
      #1 rst = 1'b1;
      #1;
      check("t6_async", {busy, shift, add, sub, nop, ready}, 0);
      void'(exp_q.pop_back());
      #1 rst = 1'b0;
      @(negedge clk);
      #1 check("t6_post", {busy, ready, 5'(iter)}, 0);
      bits = 3'b100; is_signed = 1'b1; start = 1'b1;
      exp_q.push_back(cyc + 1 + 16);
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      start = 1'b1; is_signed = 1'b0;
      #1 check("t6_ignored", {load, sub, dbl}, 3'b011);
      @(negedge clk);
      #1 check("t6_iter", iter, 2);
      start = 1'b0;
      wait_idle("t6_finish");

      repeat (3) @(negedge clk);
      check("sb_empty", exp_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
